flash_read_ctrl: RTL

FLASH_READ_CTRL -- requirements
Module: flash_read_ctrl

---
 rtl/flash_read_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/flash_read_ctrl.sv
// Asynchronous parallel-flash word reader: optional read-array command, OE wait window, data capture.
// Build option: FLASH_CMD_EVERY_READ_EN issues the read-array command on every read, not only the first after reset.
module flash_read_ctrl #(
    parameter int unsigned WAIT_CYC = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flash_need_to_work,
    input  logic [22:1] flash_addr,
    output logic        flash_work_done,
    output logic [15:0] flash_data_out,
    output logic [15:0] flash_done_addr,
    output logic [22:1] flash_a,
    inout  wire  [15:0] flash_d,
    output logic        flash_ce_n,
    output logic        flash_oe_n,
    output logic        flash_we_n,
    output logic        flash_byte_n,
    output logic        flash_vpen,
    output logic        flash_rp_n
);

    typedef enum logic [2:0] {
        IDLE,
        CMD_SETUP,
        CMD_PULSE,
        CMD_HOLD,
        RD_ADDR,
        RD_WAIT,
        DONE,
        RELEASE
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYC - 1);
    localparam logic [15:0] READ_ARRAY_CMD = 16'h00FF;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [22:1] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] daddr_q, daddr_d;

    logic        ce_n, oe_n, we_n, drive, done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b1;
            addr_q  <= '0;
            data_q  <= '0;
            daddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            daddr_q <= daddr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        addr_d  = addr_q;
        data_d  = data_q;
        daddr_d = daddr_q;
        ce_n    = 1'b1;
        oe_n    = 1'b1;
        we_n    = 1'b1;
        drive   = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (flash_need_to_work) begin
                    addr_d = flash_addr;
                    if (pend_q) begin
                        state_d = CMD_SETUP;
`ifdef FLASH_CMD_EVERY_READ_EN
                        // pending flag is never cleared, so every read takes the command path
`else
                        pend_d  = 1'b0;
`endif
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            CMD_SETUP: begin
                ce_n    = 1'b0;
                drive   = 1'b1;
                state_d = CMD_PULSE;
            end
            CMD_PULSE: begin
                ce_n    = 1'b0;
                we_n    = 1'b0;
                drive   = 1'b1;
                state_d = CMD_HOLD;
            end
            CMD_HOLD: begin
                ce_n    = 1'b0;
                drive   = 1'b1;
                state_d = RD_ADDR;
            end
            RD_ADDR: begin
                ce_n    = 1'b0;
                oe_n    = 1'b0;
                cnt_d   = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                ce_n = 1'b0;
                oe_n = 1'b0;
                if (cnt_q == LAST_CNT) begin
                    data_d  = flash_d;
                    daddr_d = addr_q[16:1];
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = RELEASE;
            end
            RELEASE: begin
                // a request still held from the finished read must drop before a new one is taken
                if (!flash_need_to_work) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign flash_d         = drive ? READ_ARRAY_CMD : 'z;
    assign flash_ce_n      = ce_n;
    assign flash_oe_n      = oe_n;
    assign flash_we_n      = we_n;
    assign flash_work_done = done;
    assign flash_data_out  = data_q;
    assign flash_done_addr = daddr_q;
    assign flash_a         = addr_q;
    assign flash_byte_n    = 1'b1;
    assign flash_vpen      = 1'b1;
    assign flash_rp_n      = 1'b1;

endmodule
